spi_xfer_arbiter: RTL
=====================

// Module: spi_xfer_arbiter
// PURPOSE
//  Shares one SPI leader engine (shift regs + clkgen) between NREQ requesters.
//  Round-robin arbitrates, loads per-requester config/TX word, drives that target's
//  chip select with setup/hold/gap timing, pulses the engine start, returns RX word.
//  Aborts hung transfers via timeout. Sits between CPU-side clients and the SPI core.
// PARAMETERS
//  NREQ     4    number of requesters / chip selects (2..8)
//  CS_SETUP 2    clk cycles from cs_n low to eng_start (>=1)
//  CS_HOLD  2    clk cycles from eng_done to cs_n high (>=1)
//  CS_GAP   4    min clk cycles all cs_n high between transfers (>=1)
//  TIMEOUT  4096 max clk cycles eng_start->eng_done before abort
// PORTS
//  clk      in  1        system clock, all logic on posedge
//  rst      in  1        asynchronous reset, active-high
//  req      in  NREQ     per-requester transfer request, level, held until done
//  req_cfg  in  NREQ*8   per-requester config byte, slice i = [8i+7:8i]:
//                        [6] len (1=16b), [5] cpol, [4] cpha, [3:1] div
//  req_tx   in  NREQ*16  per-requester TX word; 8-bit xfers use [7:0]
//  gnt      out NREQ     one-hot grant, high ARB..HOLD of owning transfer
//  done     out NREQ     one-cycle pulse per requester at transfer end
//  err      out 1        one-cycle pulse with done on timeout abort
//  rx_data  out 16       RX word of last transfer, stable until next done
//  busy     out 1        high whenever state != IDLE
//  cs_n     out NREQ     active-low chip selects, at most one low
//  eng_cfg  out 8        config to engine, bit7=1 (leader), bit0=0
//  eng_tx   out 16       TX word to engine
//  eng_start out 1       one-cycle start pulse to engine
//  eng_done in  1        engine completion pulse
//  eng_rx   in  16       engine RX word, valid with eng_done
// BEHAVIOUR
//  Reset: state IDLE, gnt/done/err/eng_start=0, rx_data/eng_cfg/eng_tx=0, cs_n=all 1,
//   rr pointer=0. Reset mid-transfer: cs_n high immediately (async), no done.
//  States: IDLE -> ARB -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
//  IDLE: if |req, pick first set bit scanning from ptr upward (wrap) -> ARB.
//  ARB (1 cycle): gnt[i]=1, cs_n[i]=0, latch eng_cfg={1,req_cfg_i[6:1],0},
//   eng_tx=req_tx_i; ptr<=i+1 mod NREQ. Config/tx changes after this ignored.
//  SETUP: count CS_SETUP cycles from cs_n low; last cycle pulses eng_start -> XFER.
//  XFER: timer from eng_start; eng_done -> rx_data<=eng_rx (8b: upper byte 0), HOLD.
//   Timer reaching TIMEOUT w/o eng_done -> HOLD with abort flag, rx_data unchanged.
//  HOLD: CS_HOLD cycles; on last: cs_n[i]=1, gnt=0, done[i]=1, err=abort -> GAP.
//  GAP: CS_GAP cycles all cs_n high, then IDLE; arbitration next cycle.
//  Latency, no contention: req rise at T -> gnt/cs_n at T+1 (ARB),
//   eng_start at T+CS_SETUP, cs_n high + done at eng_done+CS_HOLD,
//   next grant >= done+CS_GAP+1.
//  req[i] dropping mid-transfer: transfer completes, done[i] still pulses.
//  eng_done outside XFER ignored. eng_done and timeout same cycle: eng_done wins.
//  New req during busy waits; fairness: every requester served within NREQ grants.
// TESTING
//  req=0001, req_cfg0=0x08 (8b), req_tx0=0x00A5, engine returns 0x3C after 20 cyc
//   -> gnt=0001, cs_n=1110, start at T+2, done[0] and rx_data=0x003C.
//  req=0110 same cycle, ptr=0 -> req1 served first, then req2 after CS_GAP;
//   cs_n never two low at once.
//  req=1111 held 8 transfers -> grant order 0,1,2,3,0,1,2,3.
//  engine never returns eng_done -> after TIMEOUT cycles + CS_HOLD:
//   done[i]=1, err=1, rx_data unchanged.
//  rst asserted in XFER -> cs_n=1111, gnt=0, busy=0 same cycle; no done; re-arb ok.
//  req0 dropped in XFER with req_cfg len=1 -> done[0] still pulses, 16b rx_data valid.

Source files
------------

// File: rtl/spi_xfer_arbiter_if.sv
// Bus between the requesters, the arbiter and the shared SPI leader engine.
// The arbiter connects through the slave modport; the client/engine side
// (or a test environment standing in for it) uses the master modport.
interface spi_xfer_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*8-1:0]  req_cfg;
    logic [NREQ*16-1:0] req_tx;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [15:0]        rx_data;
    logic               busy;
    logic [NREQ-1:0]    cs_n;
    logic [7:0]         eng_cfg;
    logic [15:0]        eng_tx;
    logic               eng_start;
    logic               eng_done;
    logic [15:0]        eng_rx;

    modport slave (
        input  req, req_cfg, req_tx, eng_done, eng_rx,
        output gnt, done, err, rx_data, busy, cs_n, eng_cfg, eng_tx, eng_start
    );

    modport master (
        output req, req_cfg, req_tx, eng_done, eng_rx,
        input  gnt, done, err, rx_data, busy, cs_n, eng_cfg, eng_tx, eng_start
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI leader engine between NREQ requesters.
// Owns chip-select timing (setup/hold/gap), launches the engine, captures the
// RX word and aborts transfers that never complete.
module spi_xfer_arbiter #(
    parameter int NREQ     = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    spi_xfer_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + CS_SETUP + CS_HOLD + CS_GAP + 1);

    // The ARB cycle is the first setup cycle, so SETUP covers the remaining ones.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((CS_SETUP > 1) ? (CS_SETUP - 2) : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             abort;
    logic [7:0]       eng_cfg_q;
    logic [15:0]      eng_tx_q;
    logic [15:0]      rx_q;
    logic             eng_start_c;
    logic             hold_last;
    logic             grant_on;
    logic [NREQ-1:0]  own_oh;
    logic [NREQ-1:0]  gnt_c;

    // Round-robin pick: first requester at or above ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_vld && bus.req[(int'(ptr) + k) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // State register; async reset releases the chip selects immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
        end
    end

    // Next-state decode and engine start strobe.
    always_comb begin
        state_nxt   = state;
        eng_start_c = 1'b0;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_ARB;
            S_ARB: begin
                if (CS_SETUP == 1) begin
                    eng_start_c = 1'b1;
                    state_nxt   = S_XFER;
                end else begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    eng_start_c = 1'b1;
                    state_nxt   = S_XFER;
                end
            end
            // A completion on the timeout cycle still counts as a completion.
            S_XFER:  if (bus.eng_done || (cnt == TMO_LAST)) state_nxt = S_HOLD;
            S_HOLD:  if (cnt == HOLD_LAST) state_nxt = S_GAP;
            S_GAP:   if (cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Owner/pointer bookkeeping, engine config latch and RX capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= '0;
            ptr       <= '0;
            abort     <= 1'b0;
            eng_cfg_q <= '0;
            eng_tx_q  <= '0;
            rx_q      <= '0;
        end else begin
            if (state == S_IDLE && pick_vld) begin
                owner     <= pick_idx;
                ptr       <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                abort     <= 1'b0;
                eng_cfg_q <= {1'b1, bus.req_cfg[int'(pick_idx)*8 + 1 +: 6], 1'b0};
                eng_tx_q  <= bus.req_tx[int'(pick_idx)*16 +: 16];
            end
            if (state == S_XFER) begin
                if (bus.eng_done) begin
                    rx_q <= eng_cfg_q[6] ? bus.eng_rx : {8'h00, bus.eng_rx[7:0]};
                end else if (cnt == TMO_LAST) begin
                    abort <= 1'b1;
                end
            end
        end
    end

    // Grant and chip select drop together on the final hold cycle, with done.
    assign hold_last = (state == S_HOLD) && (cnt == HOLD_LAST);
    assign grant_on  = (state == S_ARB) || (state == S_SETUP) || (state == S_XFER) ||
                       ((state == S_HOLD) && !hold_last);
    assign own_oh    = NREQ'(1) << owner;
    assign gnt_c     = grant_on ? own_oh : '0;

    assign bus.gnt       = gnt_c;
    assign bus.cs_n      = ~gnt_c;
    assign bus.done      = hold_last ? own_oh : '0;
    assign bus.err       = hold_last & abort;
    assign bus.busy      = (state != S_IDLE);
    assign bus.rx_data   = rx_q;
    assign bus.eng_cfg   = eng_cfg_q;
    assign bus.eng_tx    = eng_tx_q;
    assign bus.eng_start = eng_start_c;
endmodule
